// File: rtl/i2c_cmd_queue_if.sv
// Producer request channel and I2C write-master handshake for i2c_cmd_queue.
//   slave  : queue side (takes requests, drives the master)
//   master : environment side (producer plus I2C write master)
interface i2c_cmd_queue_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              m_start;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport slave (
        input  in_valid, in_addr, in_data, m_ready,
        output in_ready, m_start, m_addr, m_data
    );

    modport master (
        output in_valid, in_addr, in_data, m_ready,
        input  in_ready, m_start, m_addr, m_data
    );
endinterface

// File: rtl/i2c_cmd_queue.sv
// Write-command FIFO plus dispatcher that feeds the I2C write master one
// request at a time and tracks acceptance and completion of each request.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   bus           request channel (in_*) and master handshake (m_*)
//   flush         synchronous: empties the FIFO and clears sticky errors
//   count         queued entries (the in-flight request is not counted)
//   busy          dispatcher not idle
//   txn_done      one-cycle pulse per completed transaction
//   err_overflow  sticky: push attempted while full
//   err_timeout   sticky: master never accepted an issued request
module i2c_cmd_queue #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned ACCEPT_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_cmd_queue_if.slave        bus,
    input  logic                  flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                  busy,
    output logic                  txn_done,
    output logic                  err_overflow,
    output logic                  err_timeout
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(ACCEPT_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACCEPT,
        WAIT_DONE
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic          m_start_d;
    logic [6:0]    m_addr_d;
    logic [7:0]    m_data_d;
    logic          txn_done_d;
    logic          pop;
    logic          timeout_ev;

    logic [6:0]    addr_mem [DEPTH];
    logic [7:0]    data_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full;
    logic          push;
    logic          overflow_ev;

    assign full        = (count == CW'(DEPTH));
    assign bus.in_ready = !full && !flush;
    assign push        = bus.in_valid && bus.in_ready;
    // A request arriving during flush is ignored rather than flagged.
    assign overflow_ev = bus.in_valid && full && !flush;
    assign busy        = (state != IDLE);

    // Storage array: written on push, read at the head pointer on issue.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.in_addr;
            data_mem[wr_ptr] <= bus.in_data;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            if (flush)            err_overflow <= 1'b0;
            else if (overflow_ev) err_overflow <= 1'b1;

            // A timeout on the flush cycle is still reported.
            if (timeout_ev) err_timeout <= 1'b1;
            else if (flush) err_timeout <= 1'b0;
        end
    end

    // Dispatcher state and master-facing registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            bus.m_start <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_data  <= '0;
            txn_done    <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            bus.m_start <= m_start_d;
            bus.m_addr  <= m_addr_d;
            bus.m_data  <= m_data_d;
            txn_done    <= txn_done_d;
        end
    end

    // Dispatcher next-state: issue, wait for m_ready to drop, wait for it to return.
    always_comb begin
        state_d    = state;
        timer_d    = timer;
        m_start_d  = 1'b0;
        m_addr_d   = bus.m_addr;
        m_data_d   = bus.m_data;
        txn_done_d = 1'b0;
        pop        = 1'b0;
        timeout_ev = 1'b0;

        case (state)
            IDLE: begin
                if (count != '0 && bus.m_ready && !flush) begin
                    pop       = 1'b1;
                    m_addr_d  = addr_mem[rd_ptr];
                    m_data_d  = data_mem[rd_ptr];
                    m_start_d = 1'b1;
                    timer_d   = '0;
                    state_d   = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (!bus.m_ready) begin
                    state_d = WAIT_DONE;
                end else if (timer == TW'(ACCEPT_TIMEOUT - 1)) begin
                    // Unaccepted request is dropped, not retried.
                    timeout_ev = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.m_ready) begin
                    txn_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Directed bench for i2c_cmd_queue with a small I2C write-master model.
module tb_i2c_cmd_queue;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TO      = 8;
    localparam int          TXN_LEN = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] count;
    logic       busy, txn_done, err_overflow, err_timeout;

    always #5 clk = ~clk;

    i2c_cmd_queue_if bus();

    i2c_cmd_queue #(.DEPTH(DEPTH), .ACCEPT_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .flush        (flush),
        .count        (count),
        .busy         (busy),
        .txn_done     (txn_done),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout)
    );

    // Master model: samples m_start, drops ready one cycle later, stays busy, then returns.
    logic ovr     = 1'b0;
    logic ovr_val = 1'b1;
    logic mdl_ready, mdl_pend;
    int   mdl_cnt;
    assign bus.m_ready = ovr ? ovr_val : mdl_ready;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_ready <= 1'b1;
            mdl_pend  <= 1'b0;
            mdl_cnt   <= 0;
        end else if (!ovr) begin
            if (mdl_pend) begin
                mdl_ready <= 1'b0;
                mdl_pend  <= 1'b0;
                mdl_cnt   <= TXN_LEN;
            end else if (mdl_ready && bus.m_start) begin
                mdl_pend <= 1'b1;
            end else if (!mdl_ready) begin
                if (mdl_cnt == 0) mdl_ready <= 1'b1;
                else              mdl_cnt   <= mdl_cnt - 1;
            end
        end
    end

    // Issue/completion log.
    int          n_start = 0;
    int          n_done  = 0;
    logic [14:0] log_q[$];
    always @(negedge clk) begin
        if (bus.m_start) begin
            n_start++;
            log_q.push_back({bus.m_addr, bus.m_data});
        end
        if (txn_done) n_done++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [6:0] a, input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget, input string tag);
        int k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(n_done), 32'(target));
    endtask

    task automatic wait_mready_low(input int budget, input string tag);
        int k = 0;
        while (bus.m_ready !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(bus.m_ready), 32'd0);
    endtask

    int          s0, d0, b;
    logic [14:0] exp_e;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;

        // Reset values
        tick(2);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_start", 32'(bus.m_start), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_m_addr", 32'(bus.m_addr), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_txn_done", 32'(txn_done), 32'd0);
        chk("rst_err_ovf", 32'(err_overflow), 32'd0);
        chk("rst_err_to", 32'(err_timeout), 32'd0);

        // Single request and issue latency
        s0 = n_start; d0 = n_done; b = log_q.size();
        push(7'h50, 8'hA5);
        chk("t1_count_after_push", 32'(count), 32'd1);
        chk("t1_no_start_yet", 32'(bus.m_start), 32'd0);
        tick();
        chk("t1_m_start", 32'(bus.m_start), 32'd1);
        chk("t1_m_addr", 32'(bus.m_addr), 32'h50);
        chk("t1_m_data", 32'(bus.m_data), 32'hA5);
        chk("t1_count_issued", 32'(count), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_start_one_cycle", 32'(bus.m_start), 32'd0);
        wait_dones(d0 + 1, 40, "t1_done");
        tick();
        chk("t1_done_one_cycle", 32'(txn_done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_starts", 32'(n_start - s0), 32'd1);
        chk("t1_log", 32'(log_q[b]), 32'h50A5);

        // Fill and overflow with master held not-ready
        ovr = 1'b1; ovr_val = 1'b0;
        s0 = n_start; d0 = n_done; b = log_q.size();
        for (int i = 0; i < 5; i++) push(7'h10 + 7'(i), 8'h20 + 8'(i));
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_err_ovf", 32'(err_overflow), 32'd1);
        chk("t2_no_issue", 32'(n_start - s0), 32'd0);
        ovr = 1'b0;
        wait_dones(d0 + 4, 200, "t2_dones");
        chk("t2_starts", 32'(n_start - s0), 32'd4);
        chk("t2_count_empty", 32'(count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_e = {7'h10 + 7'(i), 8'h20 + 8'(i)};
            chk($sformatf("t2_order%0d", i), 32'(log_q[b + i]), 32'(exp_e));
        end

        // Flush clears overflow; simultaneous push/pop; order across pointer wrap
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_err_ovf", 32'(err_overflow), 32'd0);
        ovr = 1'b1; ovr_val = 1'b0;
        s0 = n_start; d0 = n_done; b = log_q.size();
        push(7'h30, 8'h40);
        push(7'h31, 8'h41);
        chk("t3_count2", 32'(count), 32'd2);
        ovr = 1'b0;
        bus.in_valid = 1'b1; bus.in_addr = 7'h32; bus.in_data = 8'h42;
        tick();
        bus.in_valid = 1'b0;
        chk("t3_count_pushpop", 32'(count), 32'd2);
        chk("t3_start", 32'(bus.m_start), 32'd1);
        chk("t3_head_addr", 32'(bus.m_addr), 32'h30);
        wait_dones(d0 + 2, 100, "t3_two_done");
        push(7'h33, 8'h43);
        push(7'h34, 8'h44);
        push(7'h35, 8'h45);
        wait_dones(d0 + 6, 300, "t3_six_done");
        chk("t3_starts", 32'(n_start - s0), 32'd6);
        for (int i = 0; i < 6; i++) begin
            exp_e = {7'h30 + 7'(i), 8'h40 + 8'(i)};
            chk($sformatf("t3_order%0d", i), 32'(log_q[b + i]), 32'(exp_e));
        end

        // Accept timeout with m_ready stuck high
        ovr = 1'b1; ovr_val = 1'b1;
        s0 = n_start; d0 = n_done;
        push(7'h11, 8'h22);
        tick();
        chk("t4_start", 32'(bus.m_start), 32'd1);
        chk("t4_m_addr", 32'(bus.m_addr), 32'h11);
        tick(7);
        chk("t4_no_to_yet", 32'(err_timeout), 32'd0);
        chk("t4_still_busy", 32'(busy), 32'd1);
        tick();
        chk("t4_err_to", 32'(err_timeout), 32'd1);
        chk("t4_back_idle", 32'(busy), 32'd0);
        tick(4);
        chk("t4_single_start", 32'(n_start - s0), 32'd1);
        chk("t4_no_done", 32'(n_done - d0), 32'd0);
        chk("t4_count", 32'(count), 32'd0);

        // Flush while a transaction is in WAIT_DONE
        ovr = 1'b0;
        s0 = n_start; d0 = n_done; b = log_q.size();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_addr = 7'h60 + 7'(i);
            bus.in_data = 8'h70 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        wait_mready_low(10, "t5_accepted");
        tick();
        chk("t5_count3", 32'(count), 32'd3);
        chk("t5_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_count_flushed", 32'(count), 32'd0);
        chk("t5_err_to_cleared", 32'(err_timeout), 32'd0);
        chk("t5_still_busy", 32'(busy), 32'd1);
        wait_dones(d0 + 1, 40, "t5_inflight_done");
        tick(10);
        chk("t5_no_more_start", 32'(n_start - s0), 32'd1);
        chk("t5_log", 32'(log_q[b]), 32'h6070);

        // Asynchronous reset while in WAIT_DONE
        s0 = n_start; d0 = n_done;
        push(7'h0A, 8'h0B);
        push(7'h0C, 8'h0D);
        wait_mready_low(20, "t6_accepted");
        tick();
        chk("t6_busy_pre", 32'(busy), 32'd1);
        chk("t6_count_pre", 32'(count), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_m_start", 32'(bus.m_start), 32'd0);
        chk("t6_rst_m_addr", 32'(bus.m_addr), 32'd0);
        chk("t6_rst_m_data", 32'(bus.m_data), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        push(7'h3C, 8'h5A);
        wait_dones(d0 + 1, 40, "t6_post_reset_done");
        chk("t6_starts", 32'(n_start - s0), 32'd2);
        chk("t6_log", 32'(log_q[log_q.size() - 1]), 32'h3C5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
